// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame geometry
// and the parity helper used when a frame is closed.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a persistence filter for one raw PS/2 line.
// The filtered level only follows the input after FILTER_LEN agreeing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_bus,
  input  logic bus_reset,
  input  logic line_raw,
  output logic line
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours and the chain cannot race.
  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      line  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= line_raw;
      sync2 <= sync1;
      if (sync2 == line) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        line <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered line sampling, 11-bit frame FSM with
// timeout, byte FIFO, and rate-limited single-cycle delivery to the controller.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FIFO_DEPTH = 8,
  parameter int POP_GAP    = 4
) (
  input  logic                          clk_bus,
  input  logic                          bus_reset,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic [7:0]                    keyb_data,
  output logic                          keyb_valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

  logic clk_line;
  logic clk_line_d;
  logic dat_line;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_bus   (clk_bus),
    .bus_reset (bus_reset),
    .line_raw  (PS2_CLK),
    .line      (clk_line)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk_bus   (clk_bus),
    .bus_reset (bus_reset),
    .line_raw  (PS2_DAT),
    .line      (dat_line)
  );

  always_ff @(posedge clk_bus) begin
    if (bus_reset) clk_line_d <= 1'b1;
    else           clk_line_d <= clk_line;
  end

  assign fall = clk_line_d & ~clk_line;

  ps2_state_e     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_q;
  logic           par_bit;
  logic [TW-1:0]  idle_cnt;
  logic           parity_err_q;
  logic           frame_err_q;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  count;
  logic [GW-1:0]  gap_cnt;
  logic [7:0]     keyb_data_q;
  logic           valid_q;
  logic           overflow_q;

  logic good_byte;
  logic full;
  logic pop;
  logic push;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    good_byte = 1'b0;
    if (fall && state == STOP && dat_line && odd_parity({par_bit, shift_q}))
      good_byte = 1'b1;
    full = (count == LW'(FIFO_DEPTH));
    pop  = (count != '0) && (gap_cnt == '0);
    // a pop frees the slot in the same edge, so a full FIFO still accepts
    push = good_byte && (!full || pop);
  end

  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      par_bit      <= 1'b0;
      idle_cnt     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state == IDLE) begin
        idle_cnt <= '0;
        // a fall with data high is a spurious edge and is ignored
        if (fall && !dat_line) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        idle_cnt <= '0;
        case (state)
          DATA: begin
            shift_q <= {dat_line, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_line;
            state   <= STOP;
          end
          STOP: begin
            if (!dat_line)                              frame_err_q  <= 1'b1;
            else if (!odd_parity({par_bit, shift_q}))   parity_err_q <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
        state       <= IDLE;
        frame_err_q <= 1'b1;
        idle_cnt    <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only ever read
  // behind the count, which is reset, so stale bytes are never delivered.
  always_ff @(posedge clk_bus) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      keyb_data_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      valid_q    <= pop;
      overflow_q <= good_byte && full && !pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        keyb_data_q <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
        gap_cnt     <= GW'(POP_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pulses are masked while reset is high so nothing leaks in the reset cycle.
  assign keyb_data  = keyb_data_q;
  assign keyb_valid = valid_q      & ~bus_reset;
  assign parity_err = parity_err_q & ~bus_reset;
  assign frame_err  = frame_err_q  & ~bus_reset;
  assign overflow   = overflow_q   & ~bus_reset;
  assign fifo_level = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: a default-sized instance and a shallow,
// slow-popping instance, driven with hand-built PS/2 frames.
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 2000;
  localparam int GAP_A = 4;
  localparam int GAP_B = 1000;
  localparam int H_A   = 40;   // half PS/2 period, ~10 kHz for an 800 kHz bus clock
  localparam int H_B   = 12;   // fast frames to fill the shallow FIFO

  typedef enum int {EV_DATA, EV_PERR, EV_FERR, EV_OVF} ev_kind_e;
  typedef struct {
    int          id;
    ev_kind_e    kind;
    logic [7:0]  data;
    int          at;     // expected observation cycle, -1 when untimed
  } ev_t;

  ev_t qd[$];
  ev_t qe[$];

  logic clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  int cyc = 0;
  always @(posedge clk_bus) cyc <= cyc + 1;

  logic bus_reset = 1'b1;
  logic a_clk = 1'b1, a_dat = 1'b1, b_clk = 1'b1, b_dat = 1'b1;
  logic [7:0] a_data, b_data;
  logic a_valid, a_perr, a_ferr, a_ovf;
  logic b_valid, b_perr, b_ferr, b_ovf;
  logic [3:0] a_level;
  logic [1:0] b_level;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(8), .POP_GAP(GAP_A)) dut_a (
    .clk_bus(clk_bus), .bus_reset(bus_reset), .PS2_CLK(a_clk), .PS2_DAT(a_dat),
    .keyb_data(a_data), .keyb_valid(a_valid), .parity_err(a_perr),
    .frame_err(a_ferr), .overflow(a_ovf), .fifo_level(a_level)
  );

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(2), .POP_GAP(GAP_B)) dut_b (
    .clk_bus(clk_bus), .bus_reset(bus_reset), .PS2_CLK(b_clk), .PS2_DAT(b_dat),
    .keyb_data(b_data), .keyb_valid(b_valid), .parity_err(b_perr),
    .frame_err(b_ferr), .overflow(b_ovf), .fifo_level(b_level)
  );

  int checks = 0;
  int errors = 0;
  int last_fall = 0;
  int last_pop[2] = '{-1, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int id, input ev_kind_e kind, input logic [7:0] data);
    ev_t e;
    if ((kind == EV_DATA && qd.size() == 0) || (kind != EV_DATA && qe.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got %s data %02h at cycle %0d, required none",
               id, kind.name(), data, cyc);
      return;
    end
    if (kind == EV_DATA) e = qd.pop_front();
    else                 e = qe.pop_front();
    check($sformatf("event_dut dut%0d", id), id, e.id);
    check($sformatf("event_kind dut%0d", id), kind, e.kind);
    if (kind == EV_DATA) check($sformatf("keyb_data dut%0d", id), data, e.data);
    if (e.at >= 0) check($sformatf("event_cycle %s dut%0d", kind.name(), id), cyc, e.at);
  endtask

  // Monitor: every strobe or pulse is matched against the scoreboard.
  always @(negedge clk_bus) begin
    if (a_valid) begin
      observe(0, EV_DATA, a_data);
      if (last_pop[0] >= 0) check("pop_gap dut0", (cyc - last_pop[0]) >= GAP_A, 1);
      last_pop[0] = cyc;
    end
    if (b_valid) begin
      observe(1, EV_DATA, b_data);
      if (last_pop[1] >= 0) check("pop_gap dut1", (cyc - last_pop[1]) >= GAP_B, 1);
      last_pop[1] = cyc;
    end
    if (a_perr) observe(0, EV_PERR, 8'h00);
    if (a_ferr) observe(0, EV_FERR, 8'h00);
    if (a_ovf)  observe(0, EV_OVF,  8'h00);
    if (b_perr) observe(1, EV_PERR, 8'h00);
    if (b_ferr) observe(1, EV_FERR, 8'h00);
    if (b_ovf)  observe(1, EV_OVF,  8'h00);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_bus);
    #1;
  endtask

  task automatic set_lines(input int id, input logic c, input logic d);
    if (id == 0) begin a_clk = c; a_dat = d; end
    else         begin b_clk = c; b_dat = d; end
  endtask

  // Data changes while the clock is high; the host samples on the fall.
  task automatic send_bit(input int id, input logic b, input int h);
    set_lines(id, 1'b1, b);
    tick(h);
    set_lines(id, 1'b0, b);
    last_fall = cyc;
  endtask

  task automatic release_clk(input int id, input logic b, input int h);
    tick(h);
    set_lines(id, 1'b1, b);
  endtask

  // Sends one frame; the expected event is queued at the stop-bit fall.
  task automatic send_frame(input int id, input logic [7:0] d, input logic par, input logic stp,
                            input int h, input logic track, input ev_kind_e kind, input logic timed);
    logic [10:0] bits;
    ev_t e;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(id, bits[i], h);
      if (i == 10 && track) begin
        e.id   = id;
        e.kind = kind;
        e.data = d;
        e.at   = timed ? (last_fall + FL + ((kind == EV_DATA) ? 4 : 3)) : -1;
        if (kind == EV_DATA) qd.push_back(e);
        else                 qe.push_back(e);
      end
      release_clk(id, bits[i], h);
    end
    set_lines(id, 1'b1, 1'b1);
    tick(2 * h);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((qd.size() != 0 || qe.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (qd.size() != 0 || qe.size() != 0) begin
      errors++;
      $display("FAIL drain %s: got %0d events still pending after %0d cycles, required 0",
               name, qd.size() + qe.size(), budget);
      qd.delete();
      qe.delete();
    end
  endtask

  initial begin
    ev_t e;
    logic [3:0] partial;

    tick(3);
    check("reset keyb_data dut0", a_data, 8'h00);
    check("reset pulses dut0", {a_valid, a_perr, a_ferr, a_ovf}, 4'b0000);
    check("reset level dut0", a_level, 4'd0);
    check("reset pulses dut1", {b_valid, b_perr, b_ferr, b_ovf}, 4'b0000);
    check("reset level dut1", b_level, 2'd0);
    bus_reset = 1'b0;
    tick(20);

    // single scan code
    send_frame(0, 8'h1C, 1'b0, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    drain("frame_1c", 200);
    check("level_after_1c dut0", a_level, 4'd0);
    check("held keyb_data dut0", a_data, 8'h1C);

    // extended break burst
    send_frame(0, 8'hE0, 1'b0, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    send_frame(0, 8'hF0, 1'b1, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    send_frame(0, 8'h75, 1'b0, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    drain("burst", 200);

    // parity error, then recovery
    send_frame(0, 8'hF0, 1'b0, 1'b1, H_A, 1'b1, EV_PERR, 1'b1);
    send_frame(0, 8'h1C, 1'b0, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    drain("parity", 200);

    // truncated frame: start + 4 data bits, then silence until timeout
    partial = 4'b1010;
    send_bit(0, 1'b0, H_A);
    release_clk(0, 1'b0, H_A);
    for (int i = 0; i < 4; i++) begin
      send_bit(0, partial[i], H_A);
      release_clk(0, partial[i], H_A);
    end
    set_lines(0, 1'b1, 1'b1);
    e.id = 0; e.kind = EV_FERR; e.data = 8'h00; e.at = last_fall + FL + 3 + TO;
    qe.push_back(e);
    drain("timeout", TO + 200);
    send_frame(0, 8'h5A, 1'b1, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    drain("after_timeout", 200);

    // glitches on the idle clock line must be swallowed
    a_clk = 1'b0; tick(1); a_clk = 1'b1; tick(50);
    a_clk = 1'b0; tick(FL - 1); a_clk = 1'b1; tick(50);
    check("level_after_glitch dut0", a_level, 4'd0);
    send_frame(0, 8'h55, 1'b1, 1'b0, H_A, 1'b1, EV_FERR, 1'b1);
    drain("bad_stop", 200);
    send_frame(0, 8'h1C, 1'b0, 1'b1, H_A, 1'b1, EV_DATA, 1'b1);
    drain("after_glitch", 200);

    // shallow FIFO with slow consumer: fourth byte overflows
    send_frame(1, 8'h11, 1'b1, 1'b1, H_B, 1'b1, EV_DATA, 1'b1);
    send_frame(1, 8'h22, 1'b1, 1'b1, H_B, 1'b1, EV_DATA, 1'b0);
    send_frame(1, 8'h33, 1'b1, 1'b1, H_B, 1'b1, EV_DATA, 1'b0);
    send_frame(1, 8'h44, 1'b1, 1'b1, H_B, 1'b1, EV_OVF, 1'b1);
    check("level_when_full dut1", b_level, 2'd2);
    drain("overflow", 3 * GAP_B);
    check("level_after_drain dut1", b_level, 2'd0);

    // reset with a byte pending and a frame half received
    send_frame(1, 8'h66, 1'b1, 1'b1, H_B, 1'b0, EV_DATA, 1'b0);
    check("level_before_reset dut1", b_level, 2'd1);
    partial = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      send_bit(1, partial[i], H_B);
      release_clk(1, partial[i], H_B);
    end
    set_lines(1, 1'b1, 1'b1);
    bus_reset = 1'b1;
    tick(1);
    check("level_in_reset dut1", b_level, 2'd0);
    bus_reset = 1'b0;
    tick(1);
    check("level_after_reset dut1", b_level, 2'd0);
    last_pop[1] = -1;
    tick(TO + 200);
    send_frame(1, 8'h77, 1'b1, 1'b1, H_B, 1'b1, EV_DATA, 1'b1);
    drain("after_reset", 200);
    check("held keyb_data dut1", b_data, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
